// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes, ALUOp codes
// and the packed bundle of datapath control signals.
package controle_multiciclo_pkg;

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECOD       = 4'd1,
        END_MEM     = 4'd2,
        LE_MEM      = 4'd3,
        ESC_REG_MEM = 4'd4,
        ESC_MEM     = 4'd5,
        EXEC_R      = 4'd6,
        ESC_R       = 4'd7,
        EXEC_I      = 4'd8,
        ESC_I       = 4'd9,
        DESVIO      = 4'd10,
        SALTO       = 4'd11,
        ERRO        = 4'd12
    } estado_t;

    localparam logic [5:0] OP_TIPO_R = 6'h00;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_ADDI   = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       erro;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } sinais_t;

    // States that wait on mem_pronta and are therefore guarded by the timeout counter.
    function automatic logic estado_mem(estado_t e);
        return (e == BUSCA) || (e == LE_MEM) || (e == ESC_MEM);
    endfunction

endpackage

// File: rtl/controle_multiciclo_decod.sv
// Combinational output decode: control signals from the state register only,
// with the fetch-stage writes qualified by mem_pronta.
module decod_sinais_controle
    import controle_multiciclo_pkg::*;
(
    input  estado_t estado,
    input  logic    mem_pronta,
    output sinais_t sinais
);

    always_comb begin
        sinais = '0;
        case (estado)
            BUSCA: begin
                sinais.mem_read  = 1'b1;
                sinais.alu_src_b = 2'b01;
                sinais.alu_op    = ALU_ADD;
                sinais.ir_write  = mem_pronta;
                sinais.pc_write  = mem_pronta;
            end
            DECOD: begin
                sinais.alu_src_b = 2'b11;
                sinais.alu_op    = ALU_ADD;
            end
            END_MEM, EXEC_I: begin
                sinais.alu_src_a = 1'b1;
                sinais.alu_src_b = 2'b10;
                sinais.alu_op    = ALU_ADD;
            end
            LE_MEM: begin
                sinais.mem_read = 1'b1;
                sinais.ior_d    = 1'b1;
            end
            ESC_MEM: begin
                sinais.mem_write = 1'b1;
                sinais.ior_d     = 1'b1;
            end
            ESC_REG_MEM: begin
                sinais.reg_write  = 1'b1;
                sinais.mem_to_reg = 1'b1;
            end
            EXEC_R: begin
                sinais.alu_src_a = 1'b1;
                sinais.alu_op    = ALU_FUNCT;
            end
            ESC_R: begin
                sinais.reg_write = 1'b1;
                sinais.reg_dst   = 1'b1;
            end
            ESC_I: sinais.reg_write = 1'b1;
            DESVIO: begin
                sinais.alu_src_a     = 1'b1;
                sinais.alu_op        = ALU_SUB;
                sinais.pc_write_cond = 1'b1;
                sinais.pc_source     = 2'b01;
            end
            SALTO: begin
                sinais.pc_write  = 1'b1;
                sinais.pc_source = 2'b10;
            end
            ERRO:    sinais.erro = 1'b1;
            default: sinais.erro = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset controller with a bounded wait on memory; a missing mem_pronta
// or an unknown opcode parks the FSM in ERRO until reset.
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CONT_W  = 4     // must hold TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Op_code,
    input  logic       mem_pronta,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] estado,
    output logic       erro
);

    estado_t           state;
    estado_t           state_next;
    logic [CONT_W-1:0] cont;
    logic              timeout;
    sinais_t           sinais;

    assign timeout = (cont == CONT_W'(TIMEOUT));

    // Any state change clears the counter, so every memory state is entered with cont=0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BUSCA;
            cont  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cont <= '0;
            else if (estado_mem(state) && !mem_pronta)
                cont <= cont + CONT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BUSCA: begin
                if (mem_pronta)   state_next = DECOD;
                else if (timeout) state_next = ERRO;
            end
            DECOD: begin
                case (Op_code)
                    OP_TIPO_R:    state_next = EXEC_R;
                    OP_LW, OP_SW: state_next = END_MEM;
                    OP_BEQ:       state_next = DESVIO;
                    OP_J:         state_next = SALTO;
                    OP_ADDI:      state_next = EXEC_I;
                    default:      state_next = ERRO;
                endcase
            end
            END_MEM: begin
                if (Op_code == OP_LW)      state_next = LE_MEM;
                else if (Op_code == OP_SW) state_next = ESC_MEM;
                else                       state_next = ERRO;
            end
            LE_MEM: begin
                if (mem_pronta)   state_next = ESC_REG_MEM;
                else if (timeout) state_next = ERRO;
            end
            ESC_MEM: begin
                if (mem_pronta)   state_next = BUSCA;
                else if (timeout) state_next = ERRO;
            end
            ESC_REG_MEM: state_next = BUSCA;
            EXEC_R:      state_next = ESC_R;
            ESC_R:       state_next = BUSCA;
            EXEC_I:      state_next = ESC_I;
            ESC_I:       state_next = BUSCA;
            DESVIO:      state_next = BUSCA;
            SALTO:       state_next = BUSCA;
            ERRO:        state_next = ERRO;
            default:     state_next = ERRO;
        endcase
    end

    decod_sinais_controle u_decod (
        .estado     (state),
        .mem_pronta (mem_pronta),
        .sinais     (sinais)
    );

    // Writes and the error flag are forced low while reset is held, whatever the state.
    assign erro        = sinais.erro          & ~reset;
    assign PCWrite     = sinais.pc_write      & ~reset;
    assign PCWriteCond = sinais.pc_write_cond & ~reset;
    assign IRWrite     = sinais.ir_write      & ~reset;
    assign RegWrite    = sinais.reg_write     & ~reset;
    assign MemWrite    = sinais.mem_write     & ~reset;
    assign IorD        = sinais.ior_d;
    assign MemRead     = sinais.mem_read;
    assign MemtoReg    = sinais.mem_to_reg;
    assign ALUSrcA     = sinais.alu_src_a;
    assign RegDst      = sinais.reg_dst;
    assign PCSource    = sinais.pc_source;
    assign ALUOp       = sinais.alu_op;
    assign ALUSrcB     = sinais.alu_src_b;
    assign estado      = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: a table of per-cycle inputs and expected states,
// with outputs checked against a per-state expectation, plus timeout and ERRO sequences.
module tb_controle_multiciclo;

    localparam int TO = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] Op_code;
    logic       mem_pronta;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] estado;
    logic       erro;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    controle_multiciclo #(.TIMEOUT(TO), .CONT_W(4)) dut (
        .clock(clock), .reset(reset), .Op_code(Op_code), .mem_pronta(mem_pronta),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .estado(estado), .erro(erro)
    );

    // {erro,PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUOp,ALUSrcB}
    logic [16:0] out_vec;
    assign out_vec = {erro, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                      ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mp, input logic rst);
        logic e, pcw, pcc, iord, mr, mw, m2r, irw, sa, rw, rd;
        logic [1:0] pcs, aop, sb;
        {e, pcw, pcc, iord, mr, mw, m2r, irw, sa, rw, rd} = '0;
        pcs = 2'b00; aop = 2'b00; sb = 2'b00;
        case (st)
            4'd0:  begin mr = 1; sb = 2'b01; irw = mp; pcw = mp; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; sb = 2'b10; end
            4'd9:  rw = 1;
            4'd10: begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            4'd11: begin pcw = 1; pcs = 2'b10; end
            default: e = 1;
        endcase
        if (rst) {e, rw, mw, pcw, pcc, irw} = '0;
        return {e, pcw, pcc, iord, mr, mw, m2r, irw, sa, rw, rd, pcs, aop, sb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic [5:0] op, input logic mp);
        @(negedge clock);
        reset = rst; Op_code = op; mem_pronta = mp;
        #1;
    endtask

    task automatic apply_chk(input string name, input logic rst, input logic [5:0] op,
                             input logic mp, input logic [3:0] st);
        apply(rst, op, mp);
        chk({name, ".estado"}, 32'(estado), 32'(st));
        chk({name, ".ctrl"}, 32'(out_vec), 32'(exp_ctrl(st, mp, rst)));
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       mp;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b1; Op_code = 6'h00; mem_pronta = 1'b1;

        // Reset state: BUSCA with mem_pronta=1 would fetch, but writes stay gated during reset.
        apply(1, 6'h00, 1);
        apply_chk("reset", 1, 6'h00, 1, 4'd0);

        vecs = '{
            // lw, no wait: 0,1,2,3,4
            '{0, 6'h23, 1, 0}, '{0, 6'h23, 1, 1}, '{0, 6'h23, 1, 2}, '{0, 6'h23, 1, 3}, '{0, 6'h23, 1, 4},
            // sw, ESC_MEM waits 3 cycles: MemWrite for 4 cycles
            '{0, 6'h2B, 1, 0}, '{0, 6'h2B, 1, 1}, '{0, 6'h2B, 1, 2},
            '{0, 6'h2B, 0, 5}, '{0, 6'h2B, 0, 5}, '{0, 6'h2B, 0, 5}, '{0, 6'h2B, 1, 5},
            // R-type and addi
            '{0, 6'h00, 1, 0}, '{0, 6'h00, 1, 1}, '{0, 6'h00, 1, 6}, '{0, 6'h00, 1, 7},
            '{0, 6'h08, 1, 0}, '{0, 6'h08, 1, 1}, '{0, 6'h08, 1, 8}, '{0, 6'h08, 1, 9},
            // beq then j
            '{0, 6'h04, 1, 0}, '{0, 6'h04, 1, 1}, '{0, 6'h04, 1, 10},
            '{0, 6'h02, 1, 0}, '{0, 6'h02, 1, 1}, '{0, 6'h02, 1, 11},
            // fetch wait of two cycles
            '{0, 6'h00, 0, 0}, '{0, 6'h00, 0, 0}, '{0, 6'h00, 1, 0}, '{0, 6'h00, 1, 1},
            '{0, 6'h00, 1, 6}, '{0, 6'h00, 1, 7},
            // illegal opcode, sticky ERRO, reset out
            '{0, 6'h3F, 1, 0}, '{0, 6'h3F, 1, 1}, '{0, 6'h3F, 1, 12}, '{0, 6'h3F, 0, 12},
            '{1, 6'h3F, 1, 12},
            // reset while LE_MEM waits: no ESC_REG_MEM follows
            '{0, 6'h23, 1, 0}, '{0, 6'h23, 1, 1}, '{0, 6'h23, 1, 2}, '{1, 6'h23, 0, 3},
            '{0, 6'h23, 0, 0}
        };

        for (int i = 0; i < vecs.size(); i++)
            apply_chk($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].mp, vecs[i].st);

        // Sticky ERRO for 20 cycles, then reset back to BUSCA.
        apply(1, 6'h3F, 1);
        apply(0, 6'h3F, 1);
        apply(0, 6'h3F, 1);
        for (int i = 0; i < 20; i++) begin
            apply(0, 6'h3F, i[0]);
            chk($sformatf("erro_hold%0d", i), 32'({erro, estado}), 32'({1'b1, 4'd12}));
            chk($sformatf("erro_ctrl%0d", i), 32'(out_vec), 32'(exp_ctrl(4'd12, i[0], 1'b0)));
        end
        apply(1, 6'h3F, 1);
        apply(0, 6'h00, 1);
        chk("erro_reset", 32'(estado), 32'd0);

        // Timeout in BUSCA: TO+1 cycles without mem_pronta leads to ERRO.
        apply(1, 6'h00, 0);
        for (int k = 0; k <= TO; k++) begin
            apply(0, 6'h00, 0);
            chk($sformatf("to_wait%0d", k), 32'(estado), 32'd0);
        end
        apply(0, 6'h00, 0);
        chk("to_erro", 32'({erro, estado}), 32'({1'b1, 4'd12}));

        // mem_pronta on the timeout cycle wins.
        apply(1, 6'h00, 0);
        for (int k = 0; k < TO; k++) apply(0, 6'h00, 0);
        apply(0, 6'h00, 1);
        chk("to_race_fetch", 32'({IRWrite, PCWrite, estado}), 32'({2'b11, 4'd0}));
        apply(0, 6'h00, 1);
        chk("to_race_decod", 32'({erro, estado}), 32'({1'b0, 4'd1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles a memory state waits for mem_pronta before entering ERRO.
REQ-002 SHALL have parameter CONT_W, default 4, meaning the wait-counter width; TIMEOUT SHALL be less than 2**CONT_W.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port Op_code, input, 6, meaning instruction bits [31:26] from the instruction-field decoder.
REQ-006 SHALL have port mem_pronta, input, 1, meaning the memory completed the current read or write this cycle.
REQ-007 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite and RegDst, each output, 1, meaning the standard multicycle datapath controls.
REQ-008 SHALL have ports PCSource, ALUOp and ALUSrcB, each output, 2; ALUOp encodes 00=add, 01=sub, 10=use Funct.
REQ-009 SHALL have port estado, output, 4, meaning the current state code, and port erro, output, 1, meaning the controller is in ERRO.

Function
REQ-010 SHALL implement the states BUSCA, DECOD, END_MEM, LE_MEM, ESC_REG_MEM, ESC_MEM, EXEC_R, ESC_R, EXEC_I, ESC_I, DESVIO, SALTO and ERRO.
REQ-011 SHALL decode all outputs from the state register only, except that IRWrite and PCWrite in BUSCA are ANDed with mem_pronta.
REQ-012 In BUSCA it SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; it SHALL stay in BUSCA until mem_pronta=1, then go to DECOD.
REQ-013 In DECOD it SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00.
REQ-014 From DECOD it SHALL branch on Op_code: 0x00 to EXEC_R; 0x23 or 0x2B to END_MEM; 0x04 to DESVIO; 0x02 to SALTO; 0x08 to EXEC_I; any other value to ERRO.
REQ-015 In END_MEM and EXEC_I it SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00; END_MEM SHALL go to LE_MEM for 0x23 and to ESC_MEM for 0x2B.
REQ-016 In LE_MEM it SHALL drive MemRead=1 and IorD=1; in ESC_MEM it SHALL drive MemWrite=1 and IorD=1.
REQ-017 LE_MEM and ESC_MEM SHALL be held until mem_pronta=1; LE_MEM then goes to ESC_REG_MEM and ESC_MEM then goes to BUSCA.
REQ-018 In ESC_REG_MEM it SHALL drive RegWrite=1, MemtoReg=1 and RegDst=0, then go to BUSCA.
REQ-019 In EXEC_R it SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10; in ESC_R it SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0.
REQ-020 In ESC_I it SHALL drive RegWrite=1, RegDst=0 and MemtoReg=0.
REQ-021 In DESVIO it SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01.
REQ-022 In SALTO it SHALL drive PCWrite=1 and PCSource=10; DESVIO and SALTO SHALL both return to BUSCA.
REQ-023 With zero wait cycles, instruction latency from BUSCA entry to the next BUSCA entry SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-024 The wait counter SHALL clear on entry to each memory state (BUSCA, LE_MEM, ESC_MEM) and increment each cycle mem_pronta=0.
REQ-025 On the cycle the wait counter equals TIMEOUT with mem_pronta=0, the next state SHALL be ERRO.
REQ-026 A mem_pronta=1 on the same cycle as the timeout SHALL win, and the normal transition SHALL be taken.
REQ-027 ERRO SHALL be sticky until reset, with erro=1 and every write and memory-enable output 0.
REQ-028 Every output not listed for a state SHALL be 0.

Reset
REQ-029 When reset=1 at a rising edge, the next state SHALL be BUSCA and the wait counter SHALL be 0, overriding any transition, including one mid-instruction or during a memory wait.
REQ-030 While in reset, erro, RegWrite, MemWrite, PCWrite, PCWriteCond and IRWrite SHALL be 0.
REQ-031 After reset, outputs SHALL equal the BUSCA decode, with estado=0.

Structure
REQ-032 State encodings (BUSCA=0 ... ERRO=12), opcode constants and ALUOp codes SHALL live in a shared package.
REQ-033 Output decoding SHALL be a combinational sub-module named decod_sinais_controle, taking estado and mem_pronta.

Verification
REQ-034 Reset, then Op_code=0x23 with mem_pronta=1 constantly -> states 0,1,2,3,4,0; RegWrite=1 only in state 4.
REQ-035 Op_code=0x2B with mem_pronta low for 3 cycles in ESC_MEM -> MemWrite=1 for 4 cycles, then BUSCA.
REQ-036 Op_code=0x3F -> DECOD then ERRO; erro=1 holds for 20 cycles until reset=1, then BUSCA.
REQ-037 mem_pronta=0 for TIMEOUT+1 cycles in BUSCA -> ERRO; repeat with mem_pronta=1 on the timeout cycle -> DECOD.
REQ-038 Op_code=0x04 then 0x02 -> states 0,1,10,0,1,11,0, with PCSource=01 then 10.
REQ-039 Reset asserted while in LE_MEM -> BUSCA next cycle, with no RegWrite pulse.
